// File: rtl/gauss_line_buf.sv
// Raster-to-column window generator for the 5x5 Gaussian stage.
// Holds the previous N-1 lines in line memories and emits N vertically
// aligned pixels of the current column, one beat per accepted pixel.
module gauss_line_buf #(
    parameter int unsigned N     = 5,
    parameter int unsigned DW    = 8,
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned AW    = 10,
    parameter int unsigned RW    = 9
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            pix_vld,
    input  logic            pix_sof,
    input  logic [DW-1:0]   pix_in,
    output logic [N*DW-1:0] dd,
    output logic            dd_vld,
    output logic            dd_sol,
    output logic            dd_eol,
    output logic            frame_done,
    output logic            err_ovf
);

    localparam logic [AW-1:0] ColLast  = AW'(IMG_W - 1);
    localparam logic [RW-1:0] RowLast  = RW'(IMG_H - 1);
    localparam logic [RW-1:0] RowIdle  = RW'(IMG_H);
    localparam logic [RW-1:0] RowFirst = RW'(N - 1);

    logic [AW-1:0]   col_q, col_d, cur_col;
    logic [RW-1:0]   row_q, row_d, cur_row;
    logic            accept, drop, out_vld;
    logic [N*DW-1:0] win;

    // Line memories, lane 0 = oldest line; contents deliberately not reset.
    logic [DW-1:0] mem [N-1][IMG_W];

    // Beat qualification; sof restarts the frame at (0,0) even mid-frame.
    always_comb begin
        cur_col = pix_sof ? '0 : col_q;
        cur_row = pix_sof ? '0 : row_q;
        accept  = pix_vld & ((row_q < RowIdle) | pix_sof);
        drop    = pix_vld & ~accept;
        out_vld = accept & (cur_row >= RowFirst);
    end

    // Column window: old memory values (read-before-write) plus the live pixel.
    always_comb begin
        win = '0;
        for (int j = 0; j < int'(N) - 1; j++) begin
            win[j*DW +: DW] = mem[j][cur_col];
        end
        win[(N-1)*DW +: DW] = pix_in;
    end

    // Raster counters advance on accepted beats; row parks at IMG_H when idle.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (cur_col == ColLast) begin
                col_d = '0;
                row_d = cur_row + RW'(1);
            end else begin
                col_d = cur_col + AW'(1);
                row_d = cur_row;
            end
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            col_q <= '0;
            row_q <= RowIdle;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Line shift: each memory takes the next-newer line, the last takes pix_in.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int j = 0; j < int'(N) - 2; j++) begin
                mem[j][cur_col] <= mem[j+1][cur_col];
            end
            mem[N-2][cur_col] <= pix_in;
        end
    end

    // Registered outputs; dd holds its last valid window between output beats.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            dd         <= '0;
            dd_vld     <= 1'b0;
            dd_sol     <= 1'b0;
            dd_eol     <= 1'b0;
            frame_done <= 1'b0;
            err_ovf    <= 1'b0;
        end else begin
            dd_vld     <= out_vld;
            dd_sol     <= out_vld & (cur_col == '0);
            dd_eol     <= out_vld & (cur_col == ColLast);
            frame_done <= accept & (cur_row == RowLast) & (cur_col == ColLast);
            err_ovf    <= drop;
            if (out_vld) begin
                dd <= win;
            end
        end
    end

endmodule

// File: tb/tb_gauss_line_buf.sv
// Directed bench for gauss_line_buf with an 8x6 image, pixel = row*16+col.
module tb_gauss_line_buf;

    localparam int N = 5;
    localparam int DW = 8;
    localparam int IMG_W = 8;
    localparam int IMG_H = 6;

    logic            clk = 1'b0;
    logic            rst_b = 1'b0;
    logic            pix_vld = 1'b0;
    logic            pix_sof = 1'b0;
    logic [DW-1:0]   pix_in = '0;
    logic [N*DW-1:0] dd;
    logic            dd_vld, dd_sol, dd_eol, frame_done, err_ovf;

    int checks = 0;
    int errors = 0;
    int vcount;
    int fdcount;
    int ovfcount;
    logic [N*DW-1:0] exp_dd = '0;

    gauss_line_buf #(
        .N(N), .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .AW(3), .RW(3)
    ) dut (
        .clk(clk), .rst_b(rst_b), .pix_vld(pix_vld), .pix_sof(pix_sof), .pix_in(pix_in),
        .dd(dd), .dd_vld(dd_vld), .dd_sol(dd_sol), .dd_eol(dd_eol),
        .frame_done(frame_done), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One accepted pixel at (r,c); checks the window registered from this beat.
    task automatic pix(input int r, input int c, input bit sof, input logic [7:0] val);
        bit e_vld;
        @(negedge clk);
        pix_vld = 1'b1;
        pix_sof = sof;
        pix_in  = val;
        @(posedge clk);
        #1;
        e_vld = (r >= N - 1);
        if (e_vld) begin
            for (int k = 0; k < N; k++) exp_dd[k*DW +: DW] = 8'((r - (N - 1) + k) * 16 + c);
            vcount++;
        end
        if (frame_done) fdcount++;
        chk("dd_vld", 64'(dd_vld), 64'(e_vld));
        chk("dd_sol", 64'(dd_sol), 64'(e_vld && c == 0));
        chk("dd_eol", 64'(dd_eol), 64'(e_vld && c == IMG_W - 1));
        chk("dd", 64'(dd), 64'(exp_dd));
        chk("err_ovf", 64'(err_ovf), 64'd0);
        chk("frame_done", 64'(frame_done), 64'(r == IMG_H - 1 && c == IMG_W - 1));
    endtask

    // Gap cycle: nothing valid, window held.
    task automatic idle();
        @(negedge clk);
        pix_vld = 1'b0;
        pix_sof = 1'b0;
        pix_in  = 8'hA5;
        @(posedge clk);
        #1;
        chk("gap_vld", 64'(dd_vld), 64'd0);
        chk("gap_dd_hold", 64'(dd), 64'(exp_dd));
        chk("gap_fd", 64'(frame_done), 64'd0);
    endtask

    // Pixel offered with no frame in progress and no sof.
    task automatic drop_pix();
        @(negedge clk);
        pix_vld = 1'b1;
        pix_sof = 1'b0;
        pix_in  = 8'h99;
        @(posedge clk);
        #1;
        if (err_ovf) ovfcount++;
        chk("drop_ovf", 64'(err_ovf), 64'd1);
        chk("drop_vld", 64'(dd_vld), 64'd0);
        chk("drop_dd_hold", 64'(dd), 64'(exp_dd));
    endtask

    task automatic frame(input bit gaps);
        vcount  = 0;
        fdcount = 0;
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                pix(r, c, (r == 0 && c == 0), 8'(r * 16 + c));
                if (gaps) idle();
            end
        end
        chk("frame_vcount", 64'(vcount), 64'd16);
        chk("frame_fdcount", 64'(fdcount), 64'd1);
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_dd", 64'(dd), 64'd0);
        chk("rst_vld", 64'(dd_vld), 64'd0);
        chk("rst_flags", 64'({dd_sol, dd_eol, frame_done, err_ovf}), 64'd0);
        @(negedge clk);
        rst_b = 1'b1;

        // First window at row 4 col 0 is 00,10,20,30,40; last is 17..57
        frame(1'b0);
        chk("last_dd", 64'(dd), 64'h57_47_37_27_17);

        // Same frame with one gap after every pixel
        frame(1'b1);

        // Three pixels after the frame without sof are dropped
        ovfcount = 0;
        for (int i = 0; i < 3; i++) drop_pix();
        chk("ovf_count", 64'(ovfcount), 64'd3);
        idle();
        chk("ovf_clear", 64'(err_ovf), 64'd0);

        // Partial frame of junk up to row 2 col 2, then sof at row 2 col 3
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                if (r < 2 || c < 3) pix(r, c, (r == 0 && c == 0), 8'hEE);
            end
        end
        frame(1'b0);

        // Reset during row 5: outputs clear asynchronously
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                if (r < 5 || c < 3) pix(r, c, (r == 0 && c == 0), 8'(r * 16 + c));
            end
        end
        chk("pre_rst_vld", 64'(dd_vld), 64'd1);
        #2;
        pix_vld = 1'b0;
        rst_b = 1'b0;
        #1;
        chk("async_rst_dd", 64'(dd), 64'd0);
        chk("async_rst_vld", 64'(dd_vld), 64'd0);
        chk("async_rst_flags", 64'({dd_sol, dd_eol, frame_done, err_ovf}), 64'd0);
        exp_dd = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        frame(1'b0);

        // Back-to-back frames, sof right after the last pixel
        frame(1'b0);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gauss_line_buf.md
Name: gauss_line_buf

Overview:
- Raster-to-column window generator that feeds the 5x5 Gaussian convolution stage.
- Accepts one pixel per beat in raster order, holds the previous N-1 image lines in line memories, and emits N vertically aligned pixels of the current column per beat on the packed column bus consumed by the convolver.
- Sits between the grayscale pixel source and the Gaussian filter in the Canny pipeline.

Parameters:
- N, 5, window height = number of lines emitted per column (N-1 line memories)
- DW, 8, pixel width in bits
- IMG_W, 640, active pixels per line
- IMG_H, 480, active lines per frame
- AW, 10, column counter / line-memory address width; must satisfy 2^AW >= IMG_W
- RW, 9, row counter width; must satisfy 2^RW > IMG_H

Ports:
- clk, in, 1, single clock
- rst_b, in, 1, asynchronous active-low reset
- pix_vld, in, 1, pix_in valid this cycle
- pix_sof, in, 1, qualifies pixel (0,0) of a frame; sampled only when pix_vld=1
- pix_in, in, DW, input pixel
- dd, out, N*DW, column window; lane k = dd[(k+1)*DW-1:k*DW]; lane 0 = oldest line (row y-4), lane N-1 = current line (row y)
- dd_vld, out, 1, dd valid
- dd_sol, out, 1, first column of an output line (with dd_vld)
- dd_eol, out, 1, last column of an output line (with dd_vld)
- frame_done, out, 1, one-cycle pulse after last pixel of row IMG_H-1 accepted
- err_ovf, out, 1, one-cycle pulse when a pixel is dropped

Behaviour:
- Reset (async assert, sync release): col=0, row=IMG_H (idle, awaiting sof). dd=0, dd_vld=0, dd_sol=0, dd_eol=0, frame_done=0, err_ovf=0. Line memory contents are not reset.
- Accepted beat: pix_vld=1 and (row<IMG_H or pix_sof=1). pix_sof=1 forces col=0, row=0 for that beat. This applies at any time, including mid-frame: the partial frame is abandoned and no error is flagged.
- Dropped beat: pix_vld=1, row==IMG_H and pix_sof=0. The pixel is discarded, err_ovf pulses next cycle, and no state changes.
- Line memories: N-1 single-port-per-cycle arrays, IMG_W deep, addressed by col.
  - On each accepted beat at column c, read all arrays at c (read-before-write).
  - Shift: mem[j] <= mem[j+1] old value for j=0..N-3; mem[N-2] <= pix_in.
  - dd lanes = {pix_in, mem[N-2]..mem[0] old values}; lane 0 is the oldest.
- Counters advance on accepted beats only. col wraps at IMG_W-1 to 0 and row increments. After the last pixel (row IMG_H-1, col IMG_W-1), row=IMG_H and frame_done pulses next cycle.
- Output timing:
  - Latency is 1 cycle: dd, dd_vld, dd_sol and dd_eol are registered from the accepted beat.
  - dd_vld=1 only for accepted beats with row>=N-1 (priming rows 0..N-2 produce no output).
  - Output per frame is (IMG_H-N+1)*IMG_W beats. There is no bottom or edge padding; the convolver owns borders.
- dd_sol = dd_vld & (col==0); dd_eol = dd_vld & (col==IMG_W-1).
- pix_vld=0 gaps: all state holds, dd_vld=0 next cycle, and dd holds its last value.
- Flow control: none. Back-to-back pixels every cycle are supported; the downstream stage must accept one beat per cycle.
- Reset mid-frame: outputs clear immediately, and the block waits for the next sof. Stale memory contents never reach dd_vld=1, because priming rows re-fill every line before output.
- Widths: counters are unsigned; the comparisons col==IMG_W-1 and row>=N-1 are computed on the registered counters before increment.

Test Plan:
- IMG_W=8, IMG_H=6, pixel=row*16+col, continuous pix_vld with sof on (0,0):
  - no dd_vld during rows 0-3.
  - First dd_vld at row 4 col 0 gives dd lanes 0..4 = 0x00,0x10,0x20,0x30,0x40, with dd_sol=1.
  - Exactly 16 valid beats; the last has lanes 0x17,0x27,0x37,0x47,0x57 with dd_eol=1.
  - frame_done pulses once.
- Same frame with pix_vld toggled 1,0,1,0: outputs are identical in value and order, dd_vld is never asserted in gap cycles, and dd holds its value in those cycles.
- Extra 3 pixels after the frame without sof: err_ovf pulses 3 times, and there is no dd_vld and no counter change.
- sof asserted at row 2 col 3 mid-frame, then a full frame: the first dd_vld occurs 4 rows after the new sof, with data only from the new frame.
- rst_b low for 2 cycles during row 5: all outputs are 0 asynchronously; the next frame after sof produces the exact 16-beat sequence of the first test.
- Back-to-back frames, with sof on the cycle immediately after the last pixel: frame_done pulses, the second frame output matches the first, and there is no err_ovf.
